// File: rtl/conv_operand_loader_if.sv
// Signal bundle between the convolution controller, the operand RAM and the
// operand consumers of conv_operand_loader.
interface conv_operand_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int N          = 5
);
    localparam int LW = $clog2(N * N);

    logic                           ctrl_ram_en;
    logic                           ctrl_WorI;
    logic [ADDR_WIDTH-1:0]          ctrl_read_addr;
    logic [LW-1:0]                  ctrl_weight_location;
    logic                           ram_en;
    logic [ADDR_WIDTH-1:0]          ram_addr;
    logic [DATA_WIDTH-1:0]          ram_rdata;
    logic [N*N*DATA_WIDTH-1:0]      weight_bus;
    logic                           weights_loaded;
    logic [DATA_WIDTH-1:0]          pix_data;
    logic                           pix_valid;
    logic                           frame_done;
    logic                           err;

    modport slave (
        input  ctrl_ram_en, ctrl_WorI, ctrl_read_addr, ctrl_weight_location, ram_rdata,
        output ram_en, ram_addr, weight_bus, weights_loaded, pix_data, pix_valid,
               frame_done, err
    );

    modport master (
        output ctrl_ram_en, ctrl_WorI, ctrl_read_addr, ctrl_weight_location, ram_rdata,
        input  ram_en, ram_addr, weight_bus, weights_loaded, pix_data, pix_valid,
               frame_done, err
    );
endinterface

// File: rtl/conv_operand_loader.sv
// Routes RAM reads into a kernel weight register bank or a deduplicated pixel stream.
// Define LOADER_ERR_CHECK_EN to build the sticky protocol-error flag (err tied low otherwise).
module conv_operand_loader #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 11,
    parameter int N              = 5,
    parameter int RAM_LATENCY    = 1,
    parameter int IMG_START_ADDR = 0,
    parameter int IMG_PIXELS     = 784
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conv_operand_loader_if.slave  bus
);
    localparam int NN = N * N;
    localparam int LW = $clog2(NN);
    localparam logic [LW:0]           NN_V      = (LW + 1)'(NN);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_START_ADDR + IMG_PIXELS - 1);

    typedef enum logic [1:0] {W_EMPTY, W_LOADING, W_READY} w_state_t;
    typedef enum logic [1:0] {K_NONE, K_WEIGHT, K_IMAGE} kind_t;

    logic                  r_tag_vld_p  [RAM_LATENCY];
    logic                  r_tag_wori_p [RAM_LATENCY];
    logic [LW-1:0]         r_tag_loc_p  [RAM_LATENCY];
    logic [ADDR_WIDTH-1:0] r_tag_addr_p [RAM_LATENCY];

    w_state_t                  r_state, w_state_nxt;
    logic [NN-1:0]             r_mask, w_mask_nxt;
    kind_t                     r_prev_kind;
    logic [NN*DATA_WIDTH-1:0]  r_weight_bus;
    logic [DATA_WIDTH-1:0]     r_pix_data;
    logic                      r_pix_valid;
    logic                      r_frame_done;
    logic                      r_has_last;
    logic [ADDR_WIDTH-1:0]     r_last_addr;

    logic                  w_tag_vld, w_tag_wori;
    logic [LW-1:0]         w_tag_loc;
    logic [ADDR_WIDTH-1:0] w_tag_addr;
    logic                  w_wt_tag, w_img_tag, w_wt_entry, w_img_entry;
    logic                  w_loc_ok, w_wt_wr, w_img_ok, w_emit;

    assign bus.ram_en   = bus.ctrl_ram_en;
    assign bus.ram_addr = bus.ctrl_read_addr;

    // Stage p0..p(RAM_LATENCY-1): request tag travels alongside the RAM access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                r_tag_vld_p[i]  <= 1'b0;
                r_tag_wori_p[i] <= 1'b0;
                r_tag_loc_p[i]  <= '0;
                r_tag_addr_p[i] <= '0;
            end
        end else begin
            r_tag_vld_p[0]  <= bus.ctrl_ram_en;
            r_tag_wori_p[0] <= bus.ctrl_WorI;
            r_tag_loc_p[0]  <= bus.ctrl_weight_location;
            r_tag_addr_p[0] <= bus.ctrl_read_addr;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_tag_vld_p[i]  <= r_tag_vld_p[i-1];
                r_tag_wori_p[i] <= r_tag_wori_p[i-1];
                r_tag_loc_p[i]  <= r_tag_loc_p[i-1];
                r_tag_addr_p[i] <= r_tag_addr_p[i-1];
            end
        end
    end

    assign w_tag_vld  = r_tag_vld_p[RAM_LATENCY-1];
    assign w_tag_wori = r_tag_wori_p[RAM_LATENCY-1];
    assign w_tag_loc  = r_tag_loc_p[RAM_LATENCY-1];
    assign w_tag_addr = r_tag_addr_p[RAM_LATENCY-1];

    // An idle cycle resets r_prev_kind, so the next tag of either kind re-enters its phase
    assign w_wt_tag    = w_tag_vld & w_tag_wori;
    assign w_img_tag   = w_tag_vld & ~w_tag_wori;
    assign w_wt_entry  = w_wt_tag && (r_prev_kind != K_WEIGHT);
    assign w_img_entry = w_img_tag && (r_prev_kind != K_IMAGE);
    assign w_loc_ok    = {1'b0, w_tag_loc} < NN_V;
    assign w_wt_wr     = w_wt_tag & w_loc_ok;
    assign w_img_ok    = w_img_tag && (r_state == W_READY);
    assign w_emit      = w_img_ok && (w_img_entry || !r_has_last || (w_tag_addr != r_last_addr));

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        if (w_wt_entry) begin
            w_state_nxt = W_LOADING;
            w_mask_nxt  = '0;
        end else if ((r_state == W_LOADING) && (&r_mask)) begin
            w_state_nxt = W_READY;
        end
        for (int k = 0; k < NN; k++) begin
            if (w_wt_wr && (w_tag_loc == LW'(k))) w_mask_nxt[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= W_EMPTY;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    // Stage p(RAM_LATENCY): tag paired with ram_rdata commits to weights or pixel output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_kind  <= K_NONE;
            r_weight_bus <= '0;
            r_pix_data   <= '0;
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_has_last   <= 1'b0;
            r_last_addr  <= '0;
        end else begin
            r_prev_kind <= !w_tag_vld ? K_NONE : (w_tag_wori ? K_WEIGHT : K_IMAGE);
            for (int k = 0; k < NN; k++) begin
                if (w_wt_wr && (w_tag_loc == LW'(k)))
                    r_weight_bus[k*DATA_WIDTH +: DATA_WIDTH] <= bus.ram_rdata;
            end
            r_pix_valid  <= w_emit;
            r_frame_done <= w_emit && (w_tag_addr == LAST_ADDR);
            if (w_emit) begin
                r_pix_data  <= bus.ram_rdata;
                r_last_addr <= w_tag_addr;
                r_has_last  <= 1'b1;
            end else if (w_img_entry) begin
                r_has_last  <= 1'b0;
            end
        end
    end

`ifdef LOADER_ERR_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((w_wt_tag && !w_loc_ok) || (w_img_tag && (r_state != W_READY))) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.weight_bus     = r_weight_bus;
    assign bus.weights_loaded = (r_state == W_READY);
    assign bus.pix_data       = r_pix_data;
    assign bus.pix_valid      = r_pix_valid;
    assign bus.frame_done     = r_frame_done;
endmodule
